host_mem_arbiter: RTL and testbench

Round-robin OBI arbiter that shares one single-outstanding-transaction host memory port between `NUM_PORTS` requesters, e.g. the GPU host-side masters and the testbench loader. The block sits between the requesters and the host memory slave. It presents at most one request at a time and routes the memory's response back to the requester that issued it. The memory grants in the request cycle and responds exactly one cycle later for both reads and writes.

---
 rtl/host_mem_arb_pkg.sv | 20 ++
 rtl/host_mem_rr_picker.sv | 53 +++++
 rtl/host_mem_arbiter.sv | 167 ++++++++++++++++
 tb/tb_host_mem_arbiter.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/host_mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// host_mem_arb_pkg
//
// Shared types and widths for the host memory arbiter slice.
//   state_t : arbiter FSM state (IDLE = arbitration open, WAIT_RSP = one
//             transaction outstanding at the host memory).
//   DATA_W  : OBI data/address width.
//   BE_W    : OBI byte-enable width.
// -----------------------------------------------------------------------------
package host_mem_arb_pkg;

  localparam int DATA_W = 32;
  localparam int BE_W   = DATA_W / 8;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_RSP = 1'b1
  } state_t;

endpackage

// File: rtl/host_mem_rr_picker.sv
// -----------------------------------------------------------------------------
// host_mem_rr_picker
//
// Combinational round-robin winner selection.
//   req_i      : per-port request vector
//   ptr_i      : highest-priority port index (search starts here, wraps)
//   locked_i   : a previous selection is frozen awaiting grant
//   lock_idx_i : the frozen selection
//   valid_o    : a winner exists
//   winner_o   : index of the winning port
// -----------------------------------------------------------------------------
module host_mem_rr_picker #(
  parameter  int NUM_PORTS = 4,
  localparam int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [IDX_W-1:0]     ptr_i,
  input  logic                 locked_i,
  input  logic [IDX_W-1:0]     lock_idx_i,
  output logic                 valid_o,
  output logic [IDX_W-1:0]     winner_o
);

  int              cand;
  logic [IDX_W-1:0] cand_idx;

  always_comb begin
    valid_o  = 1'b0;
    winner_o = '0;
    cand     = 0;
    cand_idx = '0;
    if (locked_i) begin
      // A frozen selection is only meaningful while its requester still asks;
      // OBI forbids withdrawing req before gnt, so this is normally 1.
      valid_o  = req_i[lock_idx_i];
      winner_o = lock_idx_i;
    end else begin
      // Walk ptr, ptr+1, ... with wrap; first asserted request wins.
      for (int i = 0; i < NUM_PORTS; i++) begin
        cand = int'(ptr_i) + i;
        if (cand >= NUM_PORTS) begin
          cand = cand - NUM_PORTS;
        end
        cand_idx = cand[IDX_W-1:0];
        if (!valid_o && req_i[cand_idx]) begin
          valid_o  = 1'b1;
          winner_o = cand_idx;
        end
      end
    end
  end

endmodule

// File: rtl/host_mem_arbiter.sv
// -----------------------------------------------------------------------------
// host_mem_arbiter
//
// Round-robin OBI arbiter sharing a single-outstanding-transaction host memory
// port between NUM_PORTS requesters. At most one request is presented to the
// memory; the response (exactly one cycle after grant) is routed back to the
// requester that owns the transaction.
//
// Ports
//   clk_i, rst_ni            : clock (rising edge), async active-low reset
//   req_i/we_i               : per-port OBI request / write enable
//   be_i                     : per-port byte enables, 4 bits per port
//   addr_i/wdata_i           : per-port address / write data, 32 bits per port
//   gnt_o/rvalid_o           : per-port grant / response valid (one-hot or 0)
//   rdata_o                  : per-port read data, 0 on non-owner ports
//   mem_req_o..mem_wdata_o   : request to host memory (payload 0 when idle)
//   mem_gnt_i, mem_rvalid_i,
//   mem_rdata_i              : response from host memory
// -----------------------------------------------------------------------------
module host_mem_arbiter
  import host_mem_arb_pkg::*;
#(
  parameter  int NUM_PORTS = 4,
  localparam int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NUM_PORTS-1:0]   req_i,
  input  logic [NUM_PORTS-1:0]   we_i,
  input  logic [NUM_PORTS*4-1:0] be_i,
  input  logic [NUM_PORTS*32-1:0] addr_i,
  input  logic [NUM_PORTS*32-1:0] wdata_i,
  output logic [NUM_PORTS-1:0]   gnt_o,
  output logic [NUM_PORTS-1:0]   rvalid_o,
  output logic [NUM_PORTS*32-1:0] rdata_o,
  output logic                   mem_req_o,
  output logic                   mem_we_o,
  output logic [3:0]             mem_be_o,
  output logic [31:0]            mem_addr_o,
  output logic [31:0]            mem_wdata_o,
  input  logic                   mem_gnt_i,
  input  logic                   mem_rvalid_i,
  input  logic [31:0]            mem_rdata_i
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t           state_q,    state_d;
  logic [IDX_W-1:0] rr_ptr_q,   rr_ptr_d;
  logic [IDX_W-1:0] owner_q,    owner_d;
  logic             locked_q,   locked_d;
  logic [IDX_W-1:0] lock_idx_q, lock_idx_d;

  // ---------------------------------------------------------------------------
  // Per-port payload views and response demux
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] addr_arr  [NUM_PORTS];
  logic [DATA_W-1:0] wdata_arr [NUM_PORTS];
  logic [BE_W-1:0]   be_arr    [NUM_PORTS];

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    assign addr_arr[gi]  = addr_i[gi*32 +: 32];
    assign wdata_arr[gi] = wdata_i[gi*32 +: 32];
    assign be_arr[gi]    = be_i[gi*4 +: 4];
    // Only the port currently receiving a response sees memory data.
    assign rdata_o[gi*32 +: 32] = rvalid_o[gi] ? mem_rdata_i : '0;
  end

  // ---------------------------------------------------------------------------
  // Winner selection
  // ---------------------------------------------------------------------------
  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] pick_next;

  host_mem_rr_picker #(
    .NUM_PORTS (NUM_PORTS)
  ) u_picker (
    .req_i      (req_i),
    .ptr_i      (rr_ptr_q),
    .locked_i   (locked_q),
    .lock_idx_i (lock_idx_q),
    .valid_o    (pick_valid),
    .winner_o   (pick_idx)
  );

  // Explicit wrap so non-power-of-two port counts also cycle correctly.
  assign pick_next = (pick_idx == IDX_W'(NUM_PORTS - 1)) ? '0 : pick_idx + IDX_W'(1);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      locked_q   <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      locked_q   <= locked_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    locked_d    = locked_q;
    lock_idx_d  = lock_idx_q;

    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    gnt_o       = '0;
    rvalid_o    = '0;

    case (state_q)
      IDLE: begin
        // Any mem_rvalid_i arriving here belongs to no one and is dropped.
        if (pick_valid) begin
          mem_req_o       = 1'b1;
          mem_we_o        = we_i[pick_idx];
          mem_be_o        = be_arr[pick_idx];
          mem_addr_o      = addr_arr[pick_idx];
          mem_wdata_o     = wdata_arr[pick_idx];
          gnt_o[pick_idx] = mem_gnt_i;
          if (mem_gnt_i) begin
            owner_d  = pick_idx;
            rr_ptr_d = pick_next;
            locked_d = 1'b0;
            state_d  = WAIT_RSP;
          end else begin
            // Freeze the selection so the address phase stays stable and a
            // newly arriving request cannot preempt the pending one.
            locked_d   = 1'b1;
            lock_idx_d = pick_idx;
          end
        end else begin
          locked_d = 1'b0;
        end
      end

      WAIT_RSP: begin
        if (mem_rvalid_i) begin
          rvalid_o[owner_q] = 1'b1;
          state_d           = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_host_mem_arbiter.sv
module tb_host_mem_arbiter;

  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_ni;
  logic [N-1:0]    req_i, we_i, gnt_o, rvalid_o;
  logic [N*4-1:0]  be_i;
  logic [N*32-1:0] addr_i, wdata_i, rdata_o;
  logic            mem_req_o, mem_we_o;
  logic [3:0]      mem_be_o;
  logic [31:0]     mem_addr_o, mem_wdata_o;
  logic            mem_gnt_i, mem_rvalid_i;
  logic [31:0]     mem_rdata_i;

  host_mem_arbiter #(.NUM_PORTS(N)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .req_i        (req_i),
    .we_i         (we_i),
    .be_i         (be_i),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .gnt_o        (gnt_o),
    .rvalid_o     (rvalid_o),
    .rdata_o      (rdata_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_be_o     (mem_be_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i)
  );

  typedef struct {
    bit        we;
    bit [3:0]  be;
    bit [31:0] addr;
    bit [31:0] wdata;
    int        delay;
  } txn_t;

  typedef struct {
    int        port;
    bit [31:0] data;
    int        stamp;
  } exp_t;

  txn_t      port_q [N][$];
  txn_t      cur [N];
  bit        req_v [N];
  bit        granted [N];
  int        wait_cnt [N];
  exp_t      sb_q[$];
  bit [31:0] slave_mem [int unsigned];
  bit [31:0] ref_mem [int unsigned];
  bit        sl_pend;
  bit [31:0] sl_rdata;
  int        m_ptr, m_lock;
  bit        m_busy;
  int        glog[$];
  int        gcyc[$];
  int        gnt_block;
  bit        gnt_random;
  int        cyc;
  int        tests, fails;
  bit [31:0] last_rsp [N];

  function automatic bit [31:0] init_val(input int unsigned wa);
    bit [31:0] a;
    a = wa;
    return {~a[15:0], a[15:0] ^ 16'h5A5A};
  endfunction

  function automatic bit [31:0] be_mask(input bit [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic add_txn(input int p, input bit we, input bit [3:0] be,
                         input bit [31:0] addr, input bit [31:0] wdata, input int delay);
    txn_t t;
    t.we = we; t.be = be; t.addr = addr; t.wdata = wdata; t.delay = delay;
    port_q[p].push_back(t);
  endtask

  task automatic drive_bus();
    for (int p = 0; p < N; p++) begin
      req_i[p] = req_v[p];
      if (req_v[p]) begin
        we_i[p]            = cur[p].we;
        be_i[p*4 +: 4]     = cur[p].be;
        addr_i[p*32 +: 32] = cur[p].addr;
        wdata_i[p*32 +: 32] = cur[p].wdata;
      end else begin
        // Idle ports present junk so a wrong payload mux shows up.
        we_i[p]            = 1'($urandom_range(0, 1));
        be_i[p*4 +: 4]     = 4'($urandom);
        addr_i[p*32 +: 32] = $urandom;
        wdata_i[p*32 +: 32] = $urandom;
      end
    end
  endtask

  // Reference model: evaluated once per cycle with stable inputs.
  task automatic model_check();
    int        w;
    bit        exp_req, exp_we;
    bit [3:0]  exp_be;
    bit [31:0] exp_addr, exp_wdata;
    bit [N-1:0] exp_gnt;
    w = -1; exp_req = 0; exp_we = 0; exp_be = 0; exp_addr = 0; exp_wdata = 0; exp_gnt = 0;
    if (m_busy) begin
      m_busy = 0;
    end else begin
      if (m_lock >= 0) w = m_lock;
      else begin
        for (int k = 0; k < N; k++) begin
          int idx;
          idx = (m_ptr + k) % N;
          if (w < 0 && req_v[idx]) w = idx;
        end
      end
      if (w >= 0) begin
        exp_req = 1; exp_we = cur[w].we; exp_be = cur[w].be;
        exp_addr = cur[w].addr; exp_wdata = cur[w].wdata;
        if (mem_gnt_i) exp_gnt[w] = 1'b1;
      end
    end
    chk("mem_req",   32'(mem_req_o),  32'(exp_req));
    chk("mem_we",    32'(mem_we_o),   32'(exp_we));
    chk("mem_be",    32'(mem_be_o),   32'(exp_be));
    chk("mem_addr",  mem_addr_o,      exp_addr);
    chk("mem_wdata", mem_wdata_o,     exp_wdata);
    chk("gnt",       32'(gnt_o),      32'(exp_gnt));
    for (int p = 0; p < N; p++) begin
      if (gnt_o[p]) begin
        glog.push_back(p);
        gcyc.push_back(cyc);
        granted[p] = 1;
      end
    end
    if (w >= 0) begin
      if (mem_gnt_i) begin
        exp_t        e;
        int unsigned a;
        bit [31:0]   old, m;
        a   = cur[w].addr >> 2;
        old = ref_mem.exists(a) ? ref_mem[a] : init_val(a);
        m   = be_mask(cur[w].be);
        e.port = w; e.stamp = cyc;
        if (cur[w].we) begin
          ref_mem[a] = (old & ~m) | (cur[w].wdata & m);
          e.data = 32'h0;
        end else begin
          e.data = old;
        end
        sb_q.push_back(e);
        m_ptr = (w + 1) % N; m_lock = -1; m_busy = 1;
      end else begin
        m_lock = w;
      end
    end
    // Host memory slave: acts on what actually appears on mem_*.
    if (mem_req_o && mem_gnt_i) begin
      int unsigned a;
      bit [31:0]   old, m;
      a   = mem_addr_o >> 2;
      old = slave_mem.exists(a) ? slave_mem[a] : init_val(a);
      m   = be_mask(mem_be_o);
      if (mem_we_o) begin
        slave_mem[a] = (old & ~m) | (mem_wdata_o & m);
        sl_rdata = 32'h0;
      end else begin
        sl_rdata = old;
      end
      sl_pend = 1;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    cyc++;
    #1;
    if (sl_pend) begin
      mem_rvalid_i = 1'b1; mem_rdata_i = sl_rdata; sl_pend = 0;
    end else begin
      mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
    end
    mem_gnt_i = 1'b0;
    for (int p = 0; p < N; p++) begin
      if (granted[p]) begin
        req_v[p] = 0; granted[p] = 0;
      end
      if (!req_v[p] && port_q[p].size() > 0) begin
        if (wait_cnt[p] >= port_q[p][0].delay) begin
          cur[p] = port_q[p].pop_front();
          req_v[p] = 1; wait_cnt[p] = 0;
        end else begin
          wait_cnt[p]++;
        end
      end
    end
    drive_bus();
    @(negedge clk);
    if (gnt_block > 0) begin
      mem_gnt_i = 1'b0;
      if (mem_req_o) gnt_block--;
    end else begin
      mem_gnt_i = mem_req_o && (!gnt_random || $urandom_range(0, 2) != 0);
    end
    #1;
    model_check();
  endtask

  task automatic run_until_idle(input string name, input int budget);
    int  n;
    bit  busy;
    n = 0;
    busy = 1;
    while (busy && n < budget) begin
      cycle();
      n++;
      busy = sl_pend || m_busy || (sb_q.size() != 0);
      for (int p = 0; p < N; p++)
        if (req_v[p] || port_q[p].size() != 0) busy = 1;
    end
    tests++;
    if (busy) begin
      fails++;
      $display("FAIL %s_timeout: still busy after %0d cycles, required idle", name, n);
    end
  endtask

  task automatic chk_order(input string name, input int e[$]);
    chk({name, "_count"}, 32'(glog.size()), 32'(e.size()));
    for (int i = 0; i < e.size(); i++)
      if (i < glog.size()) chk(name, 32'(glog[i]), 32'(e[i]));
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a response.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_ni) begin
        while (sb_q.size() > 0 && sb_q[0].stamp < cyc - 1) begin
          exp_t e;
          e = sb_q.pop_front();
          tests++; fails++;
          $display("FAIL rsp_missing: port %0d got no rvalid, required one at cycle %0d", e.port, e.stamp + 1);
        end
        if (rvalid_o != '0) begin
          if (sb_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL rsp_stray: got rvalid_o=%b, required none at cycle %0d", rvalid_o, cyc);
          end else begin
            exp_t       e;
            bit [31:0]  lane;
            bit [N-1:0] ev;
            e = sb_q.pop_front();
            ev = '0; ev[e.port] = 1'b1;
            lane = rdata_o[e.port*32 +: 32];
            chk("rvalid_vec",  32'(rvalid_o), 32'(ev));
            chk("rdata",       lane, e.data);
            chk("rsp_latency", 32'(cyc), 32'(e.stamp + 1));
            for (int p = 0; p < N; p++)
              if (p != e.port) chk("rdata_other_lane", rdata_o[p*32 +: 32], 32'h0);
            last_rsp[e.port] = lane;
            $display("[TB] rsp port %0d data 0x%08h cycle %0d", e.port, lane, cyc);
          end
        end
      end
    end
  end

  initial begin
    int e[$];
    tests = 0; fails = 0; cyc = 0;
    rst_ni = 1'b0;
    mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
    sl_pend = 0; m_ptr = 0; m_lock = -1; m_busy = 0;
    gnt_block = 0; gnt_random = 0;
    for (int p = 0; p < N; p++) begin
      req_v[p] = 0; granted[p] = 0; wait_cnt[p] = 0; last_rsp[p] = 0;
    end
    drive_bus();
    slave_mem[0]  = 32'hAAAAAAAA; ref_mem[0]  = 32'hAAAAAAAA;
    slave_mem[16] = 32'hDEADBEEF; ref_mem[16] = 32'hDEADBEEF;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_req",  32'(mem_req_o), 32'h0);
    chk("rst_mem_addr", mem_addr_o, 32'h0);
    chk("rst_gnt",      32'(gnt_o), 32'h0);
    chk("rst_rvalid",   32'(rvalid_o), 32'h0);
    for (int p = 0; p < N; p++) chk("rst_rdata", rdata_o[p*32 +: 32], 32'h0);

    // Fairness: all ports request from reset
    for (int p = 0; p < N; p++) begin
      add_txn(p, 0, 4'hF, 32'(p * 4), 0, 0);
      add_txn(p, 0, 4'hF, 32'(p * 4 + 32), 0, 0);
    end
    @(negedge clk);
    rst_ni = 1'b1;
    glog.delete(); gcyc.delete();
    run_until_idle("fair", 100);
    e = '{0, 1, 2, 3, 0, 1, 2, 3};
    chk_order("fair_order", e);
    for (int i = 0; i < 7; i++)
      if (gcyc.size() > i + 1) chk("fair_spacing", 32'(gcyc[i+1] - gcyc[i]), 32'd2);

    // Single read, port 2
    glog.delete();
    add_txn(2, 0, 4'hF, 32'h40, 0, 0);
    run_until_idle("single", 20);
    e = '{2};
    chk_order("single_order", e);
    chk("single_rdata", last_rsp[2], 32'hDEADBEEF);

    // Byte-enable write then readback, port 0
    glog.delete();
    add_txn(0, 1, 4'b0101, 32'h0, 32'h11223344, 0);
    add_txn(0, 0, 4'hF, 32'h0, 0, 0);
    run_until_idle("write", 20);
    e = '{0, 0};
    chk_order("write_order", e);
    chk("write_readback", last_rsp[0], 32'hAA22AA44);

    // Bring the pointer to 0
    glog.delete();
    add_txn(3, 0, 4'hF, 32'h10, 0, 0);
    run_until_idle("ptr0", 20);
    e = '{3};
    chk_order("ptr0_order", e);

    // Lock: port 1 stalled by slave, port 0 arrives during the stall
    glog.delete();
    gnt_block = 3;
    add_txn(1, 0, 4'hF, 32'h8, 0, 0);
    add_txn(0, 0, 4'hF, 32'hC, 0, 2);
    run_until_idle("lock", 30);
    e = '{1, 0};
    chk_order("lock_order", e);

    // Bring the pointer to 2
    glog.delete();
    add_txn(1, 0, 4'hF, 32'h14, 0, 0);
    run_until_idle("ptr2", 20);
    e = '{1};
    chk_order("ptr2_order", e);

    // Simultaneous 1 and 3 with pointer at 2
    glog.delete();
    add_txn(1, 0, 4'hF, 32'h18, 0, 0);
    add_txn(3, 1, 4'hF, 32'h1C, 32'hCAFEF00D, 0);
    run_until_idle("simul", 20);
    e = '{3, 1};
    chk_order("simul_order", e);

    // Pointer should now be 2 again: 0 and 2 together -> 2 first
    glog.delete();
    add_txn(0, 0, 4'hF, 32'h20, 0, 0);
    add_txn(2, 0, 4'hF, 32'h24, 0, 0);
    run_until_idle("ptr_after", 20);
    e = '{2, 0};
    chk_order("ptr_after_order", e);

    // Reset while a read is outstanding
    glog.delete();
    add_txn(2, 0, 4'hF, 32'h44, 0, 0);
    cycle();
    e = '{2};
    chk_order("midop_grant", e);
    @(posedge clk);
    cyc++;
    #1;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hBAD0BAD0;
    rst_ni = 1'b0;
    for (int p = 0; p < N; p++) begin
      port_q[p].delete(); req_v[p] = 0; granted[p] = 0; wait_cnt[p] = 0;
    end
    sb_q.delete();
    m_ptr = 0; m_lock = -1; m_busy = 0; sl_pend = 0;
    drive_bus();
    #1;
    chk("midrst_mem_req", 32'(mem_req_o), 32'h0);
    chk("midrst_gnt",     32'(gnt_o), 32'h0);
    chk("midrst_rvalid",  32'(rvalid_o), 32'h0);
    for (int p = 0; p < N; p++) chk("midrst_rdata", rdata_o[p*32 +: 32], 32'h0);
    @(negedge clk);
    rst_ni = 1'b1;
    #1;
    chk("midrst_stray_rvalid", 32'(rvalid_o), 32'h0);
    glog.delete();
    add_txn(0, 0, 4'hF, 32'h48, 0, 0);
    add_txn(1, 0, 4'hF, 32'h4C, 0, 0);
    run_until_idle("post_rst", 20);
    e = '{0, 1};
    chk_order("post_rst_order", e);

    // Randomized traffic with random grant stalls
    gnt_random = 1;
    for (int p = 0; p < N; p++)
      for (int i = 0; i < 40; i++)
        add_txn(p, 1'($urandom_range(0, 1)), 4'($urandom), 32'($urandom_range(0, 15)) << 2,
                $urandom, int'($urandom_range(0, 3)));
    run_until_idle("random", 4000);

    chk("sb_drained", 32'(sb_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
